// File: rtl/fp_vec_pack_pkg.sv
// fp_vec_pack_pkg: fixed-point lane conventions shared by the packer and the MAC operand unpacking
package fp_vec_pack_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DATA_LENGTH = 4;
  function automatic int frac_bits(input int dw);
    return dw / 2;
  endfunction
  function automatic int int_bits(input int dw);
    return dw - dw / 2;
  endfunction
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction
  // lane k occupies [dw*(k+1)-1 : dw*k], lane 0 at the LSB end
  function automatic int lane_lsb(input int k, input int dw);
    return k * dw;
  endfunction
endpackage

// File: rtl/fp_vec_pack.sv
// fp_vec_pack: collects scalar fixed-point samples into one packed MAC operand vector
module fp_vec_pack
  import fp_vec_pack_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_LENGTH = DEF_DATA_LENGTH,
  localparam int CW = count_width(DATA_LENGTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  input  logic                              in_last,
  output logic                              in_ready,
  output logic [DATA_WIDTH*DATA_LENGTH-1:0] out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CW-1:0]                     out_count
);
  localparam int VW = DATA_WIDTH * DATA_LENGTH;
  logic [VW-1:0] asm_q, asm_n;
  logic [CW-1:0] idx;
  logic pend, acc, free, done;
  assign in_ready = !pend;
  assign acc = in_valid && !pend;
  assign free = !out_valid || out_ready;
  assign done = acc && (idx == CW'(DATA_LENGTH - 1) || in_last);
  for (genvar k = 0; k < DATA_LENGTH; k++) begin : g_lane
    assign asm_n[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = (acc && idx == CW'(k)) ? in_data
                                                        : asm_q[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
  end
  // while pending, idx holds the completed vector's lane count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q <= '0;
      idx <= '0;
      pend <= 1'b0;
      out_data <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else if (pend && free) begin
      out_data <= asm_q;
      out_count <= idx;
      out_valid <= 1'b1;
      asm_q <= '0;
      idx <= '0;
      pend <= 1'b0;
    end else if (done && free) begin
      out_data <= asm_n;
      out_count <= idx + 1'b1;
      out_valid <= 1'b1;
      asm_q <= '0;
      idx <= '0;
    end else begin
      asm_q <= asm_n;
      idx <= acc ? idx + 1'b1 : idx;
      pend <= pend || done;
      out_valid <= out_valid && !out_ready;
    end
  end
endmodule
